pc_sequencer: RTL and testbench

//  Parametrised program-counter unit for the single-cycle core; successor to the basic PC register.

---
 rtl/pc_sequencer.sv | 96 +++++++++
 tb/tb_pc_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-fetch-address unit with circular return-address stack and RUN/HALTED control.
// A full stack overwrites its oldest entry on CALL; an empty stack redirects RET to TRAP_PC.
module pc_sequencer #(
    parameter int                ADDR_W    = 32,
    parameter int                STEP      = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b1}} << 2,
    parameter logic [ADDR_W-1:0] TRAP_PC   = 'h100,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              BUSYWAIT,
    input  logic              HALT,
    input  logic              TRAP,
    input  logic              BRANCH_TAKEN,
    input  logic              JUMP,
    input  logic              CALL,
    input  logic              RET,
    input  logic [ADDR_W-1:0] TARGET,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PC_NEXT_SEQ,
    output logic              HALTED,
    output logic              RAS_EMPTY,
    output logic              RAS_FULL,
    output logic              RAS_ERR
);
    localparam int PW = $clog2(RAS_DEPTH);

    typedef enum logic {RUN, HALT_ST} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PW-1:0]     sp_q, sp_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              push;

    assign PC          = pc_q;
    assign PC_NEXT_SEQ = pc_q + ADDR_W'(STEP);
    assign HALTED      = state_q == HALT_ST;
    assign RAS_EMPTY   = cnt_q == '0;
    assign RAS_FULL    = cnt_q == (PW+1)'(RAS_DEPTH);
    assign RAS_ERR     = err_q;

    // sp_q is the next write slot; when full it already points at the oldest entry
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        push    = 1'b0;
        if (state_q == RUN && !BUSYWAIT) begin
            if (HALT) state_d = HALT_ST;
            else if (TRAP) pc_d = TRAP_PC;
            else if (RET) begin
                if (RAS_EMPTY) begin
                    pc_d  = TRAP_PC;
                    err_d = 1'b1;
                end else begin
                    pc_d  = ras_q[sp_q - 1'b1];
                    sp_d  = sp_q - 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end
            end else if (CALL) begin
                push  = 1'b1;
                pc_d  = TARGET;
                sp_d  = sp_q + 1'b1;
                cnt_d = RAS_FULL ? cnt_q : cnt_q + 1'b1;
                err_d = err_q | RAS_FULL;
            end else if (JUMP || BRANCH_TAKEN) pc_d = TARGET;
            else pc_d = PC_NEXT_SEQ;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            sp_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) ras_q[sp_q] <= PC_NEXT_SEQ;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table, halt/reset sequences and a randomized run
// against a queue-based model of the pc_sequencer.
module tb_pc_sequencer;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
    localparam logic [31:0] TRP_PC = 32'h0000_0100;

    logic        clk = 1'b0, rst = 1'b1;
    logic        busy, halt, trap, br, jmp, call, ret;
    logic [31:0] tgt, pc, pc_seq;
    logic        halted, emp, full, err;
    int          tests = 0, fails = 0;

    typedef struct {
        string       f;
        logic [31:0] tgt, pc;
        logic        emp, full, err, hlt;
    } vec_t;
    vec_t vq[$];

    logic [31:0] m_pc;
    logic        m_hlt, m_err;
    logic [31:0] m_q[$];

    pc_sequencer dut (
        .CLK(clk), .RESET(rst), .BUSYWAIT(busy), .HALT(halt), .TRAP(trap),
        .BRANCH_TAKEN(br), .JUMP(jmp), .CALL(call), .RET(ret), .TARGET(tgt),
        .PC(pc), .PC_NEXT_SEQ(pc_seq), .HALTED(halted), .RAS_EMPTY(emp),
        .RAS_FULL(full), .RAS_ERR(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", n, a, e);
        end
    endtask

    task automatic add(input string f, input logic [31:0] t, input logic [31:0] p,
                       input logic e, input logic fu, input logic er, input logic h);
        vq.push_back('{f, t, p, e, fu, er, h});
    endtask

    task automatic drive(input string f, input logic [31:0] t);
        {busy, halt, trap, br, jmp, call, ret} = '0;
        tgt = t;
        for (int i = 0; i < f.len(); i++)
            case (f[i])
                "B": busy = 1'b1;
                "H": halt = 1'b1;
                "T": trap = 1'b1;
                "b": br   = 1'b1;
                "J": jmp  = 1'b1;
                "C": call = 1'b1;
                "R": ret  = 1'b1;
                default: ;
            endcase
    endtask

    task automatic m_reset();
        m_pc = RST_PC; m_hlt = 1'b0; m_err = 1'b0; m_q.delete();
    endtask

    task automatic m_step();
        if (m_hlt || busy) return;
        if (halt) m_hlt = 1'b1;
        else if (trap) m_pc = TRP_PC;
        else if (ret) begin
            if (m_q.size() > 0) m_pc = m_q.pop_back();
            else begin m_pc = TRP_PC; m_err = 1'b1; end
        end else if (call) begin
            m_q.push_back(m_pc + 32'd4);
            if (m_q.size() > 4) begin void'(m_q.pop_front()); m_err = 1'b1; end
            m_pc = tgt;
        end else if (jmp || br) m_pc = tgt;
        else m_pc = m_pc + 32'd4;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive("", '0);
        #1;
        chk("reset PC", pc, RST_PC);
        chk("reset flags", {halted, emp, full, err}, 4'b0100);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        drive("", '0);
        add("",    0,            32'h0000_0000, 1, 0, 0, 0);
        add("",    0,            32'h0000_0004, 1, 0, 0, 0);
        add("",    0,            32'h0000_0008, 1, 0, 0, 0);
        add("BJ",  32'h40,       32'h0000_0008, 1, 0, 0, 0);
        add("BJ",  32'h40,       32'h0000_0008, 1, 0, 0, 0);
        add("J",   32'h40,       32'h0000_0040, 1, 0, 0, 0);
        add("J",   32'h10,       32'h0000_0010, 1, 0, 0, 0);
        add("C",   32'h200,      32'h0000_0200, 0, 0, 0, 0);
        add("R",   0,            32'h0000_0014, 1, 0, 0, 0);
        add("C",   32'h300,      32'h0000_0300, 0, 0, 0, 0);
        add("C",   32'h400,      32'h0000_0400, 0, 0, 0, 0);
        add("C",   32'h500,      32'h0000_0500, 0, 0, 0, 0);
        add("C",   32'h600,      32'h0000_0600, 0, 1, 0, 0);
        add("C",   32'h700,      32'h0000_0700, 0, 1, 1, 0);
        add("R",   0,            32'h0000_0604, 0, 0, 1, 0);
        add("R",   0,            32'h0000_0504, 0, 0, 1, 0);
        add("R",   0,            32'h0000_0404, 0, 0, 1, 0);
        add("R",   0,            32'h0000_0304, 1, 0, 1, 0);
        add("R",   0,            32'h0000_0100, 1, 0, 1, 0);
        add("C",   32'h800,      32'h0000_0800, 0, 0, 1, 0);
        add("TCb", 32'h900,      32'h0000_0100, 0, 0, 1, 0);
        add("R",   0,            32'h0000_0104, 1, 0, 1, 0);
        add("CR",  32'h500,      32'h0000_0100, 1, 0, 1, 0);
        add("J",   32'hFFFF_FFF8, 32'hFFFF_FFF8, 1, 0, 1, 0);
        add("",    0,            32'hFFFF_FFFC, 1, 0, 1, 0);
        add("",    0,            32'h0000_0000, 1, 0, 1, 0);
        add("H",   32'h500,      32'h0000_0000, 1, 0, 1, 1);

        #12;
        chk("reset PC", pc, RST_PC);
        chk("reset flags", {halted, emp, full, err}, 4'b0100);
        @(negedge clk);
        rst = 1'b0;
        foreach (vq[i]) begin
            drive(vq[i].f, vq[i].tgt);
            @(posedge clk); #1;
            chk($sformatf("vec%0d PC", i), pc, vq[i].pc);
            chk($sformatf("vec%0d PC_NEXT_SEQ", i), pc_seq, vq[i].pc + 32'd4);
            chk($sformatf("vec%0d flags", i), {halted, emp, full, err},
                {vq[i].hlt, vq[i].emp, vq[i].full, vq[i].err});
        end

        for (int i = 0; i < 10; i++) begin
            drive(i[0] ? "CJ" : "BT", 32'h500);
            @(posedge clk); #1;
            chk("halted PC", pc, 32'h0);
            chk("halted flag", {31'd0, halted}, 32'd1);
        end
        #2 rst = 1'b1;
        #1;
        chk("async reset PC", pc, RST_PC);
        chk("async reset flags", {halted, emp, full, err}, 4'b0100);
        @(negedge clk);
        rst = 1'b0;

        for (int blk = 0; blk < 5; blk++) begin
            do_reset();
            m_reset();
            for (int c = 0; c < 60; c++) begin
                busy = $urandom_range(4) == 0;
                halt = $urandom_range(59) == 0;
                trap = $urandom_range(15) == 0;
                br   = $urandom_range(3) == 0;
                jmp  = $urandom_range(5) == 0;
                call = $urandom_range(2) == 0;
                ret  = $urandom_range(2) == 0;
                tgt  = $urandom();
                m_step();
                @(posedge clk); #1;
                chk("rand PC", pc, m_pc);
                chk("rand PC_NEXT_SEQ", pc_seq, m_pc + 32'd4);
                chk("rand flags", {halted, emp, full, err},
                    {m_hlt, m_q.size() == 0, m_q.size() == 4, m_err});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
